// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared constants, FSM encoding and byte-lane helper for the plaintext unpacker
package aes_stream_pkg;

    localparam int BLK_BYTES  = 16;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Byte 0 sits in bits 127:120, so lane idx starts at bit (15-idx)*8.
    function automatic logic [7:0] blk_byte(input logic [127:0] blk, input logic [3:0] idx);
        return blk[{~idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/pkcs7_check.sv
// rtl/pkcs7_check.sv - combinational PKCS#7 padding validator for one 128-bit block
module pkcs7_check
    import aes_stream_pkg::*;
(
    input  logic [127:0] blk,
    output logic         pad_ok,
    output logic [4:0]   cnt
);

    logic [7:0] p;
    logic [7:0] first;
    logic [4:0] cnt_raw;
    logic       match;

    always_comb begin
        p       = blk_byte(blk, 4'd15);
        first   = 8'(BLK_BYTES) - p;
        cnt_raw = 5'd16 - p[4:0];
        match   = 1'b1;
        // Every byte from lane 16-p through lane 15 must repeat the pad value.
        for (int i = 0; i < BLK_BYTES; i++) begin
            if ((8'(i) >= first) && (blk_byte(blk, 4'(i)) != p)) begin
                match = 1'b0;
            end
        end
        pad_ok = (p >= 8'd1) && (p <= 8'd16) && match;
        cnt    = pad_ok ? cnt_raw : 5'd0;
    end

endmodule

// File: rtl/aes_plain_unpacker.sv
// rtl/aes_plain_unpacker.sv - buffers decrypted blocks, strips PKCS#7 padding, streams plaintext bytes
module aes_plain_unpacker
    import aes_stream_pkg::*;
#(
    parameter bit PAD_EN = 1'b1,
    parameter int BLK_W  = 128
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             blk_valid,
    input  logic [BLK_W-1:0] blk_data,
    input  logic             blk_last,
    output logic             blk_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             msg_done,
    output logic             pad_err,
    output logic             ovf_err
);

    logic [BLK_W:0]   fifo_mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [BLK_W-1:0] head_data;
    logic             head_last;

    state_t           state;
    state_t           state_next;
    logic [BLK_W-1:0] sreg;
    logic [4:0]       idx;
    logic [4:0]       cnt;
    logic             cur_last;
    logic             accept;

    logic             pad_ok;
    logic [4:0]       chk_cnt;
    logic [4:0]       load_cnt;
    logic             load_bad;

    assign fifo_full  = (fifo_cnt == 2'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign push       = blk_valid && !fifo_full;
    assign head_data  = fifo_mem[rd_ptr][BLK_W:1];
    assign head_last  = fifo_mem[rd_ptr][0];
    assign blk_ready  = !fifo_full;

    always_ff @(posedge clk) begin
        if (rest) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            ovf_err  <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {blk_data, blk_last};
                wr_ptr           <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 2'd1;
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - 2'd1;
            end
            if (blk_valid && fifo_full) begin
                ovf_err <= 1'b1;
            end
        end
    end

    pkcs7_check u_pkcs7_check (
        .blk    (head_data),
        .pad_ok (pad_ok),
        .cnt    (chk_cnt)
    );

    // Only a final block is subject to padding removal.
    assign load_bad = PAD_EN && head_last && !pad_ok;
    assign load_cnt = (PAD_EN && head_last) ? chk_cnt : 5'(BLK_BYTES);

    assign out_valid = (state == STREAM);
    assign msg_done  = (state == FINISH);
    assign out_byte  = sreg[BLK_W-1 -: 8];

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                pop        = 1'b1;
                state_next = (load_cnt != 5'd0) ? STREAM : FINISH;
            end
            STREAM: begin
                if (out_ready) begin
                    accept = 1'b1;
                    if (idx == (cnt - 5'd1)) begin
                        if (cur_last) begin
                            state_next = FINISH;
                        end else if (!fifo_empty) begin
                            state_next = LOAD;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            FINISH: begin
                state_next = fifo_empty ? IDLE : LOAD;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state    <= IDLE;
            sreg     <= '0;
            idx      <= 5'd0;
            cnt      <= 5'd0;
            cur_last <= 1'b0;
            pad_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (pop) begin
                sreg     <= head_data;
                idx      <= 5'd0;
                cnt      <= load_cnt;
                cur_last <= head_last;
                if (load_bad) begin
                    pad_err <= 1'b1;
                end
            end else if (accept) begin
                sreg <= {sreg[BLK_W-9:0], 8'h00};
                idx  <= idx + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_plain_unpacker.sv
// tb/tb_aes_plain_unpacker.sv - self-checking bench for aes_plain_unpacker against a byte-queue reference model
module tb_aes_plain_unpacker;

    logic         clk = 1'b0;
    logic         rest;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_last;
    logic         blk_ready;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         msg_done;
    logic         pad_err;
    logic         ovf_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    int         exp_dones = 0;
    bit         exp_pad   = 1'b0;
    bit         exp_ovf   = 1'b0;

    int first_iter;
    int last_iter;
    int done_iter;
    int gaps;
    int done_seen;

    always #5 clk = ~clk;

    aes_plain_unpacker dut (
        .clk       (clk),
        .rest      (rest),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .blk_ready (blk_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .msg_done  (msg_done),
        .pad_err   (pad_err),
        .ovf_err   (ovf_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: a block contributes its plaintext bytes in order; a final
    // block keeps 16-p bytes when its tail is p copies of p (1..16), else none.
    function automatic void model_push(input logic [127:0] d, input bit last);
        logic [7:0] b [16];
        int n;
        int p;
        bit ok;
        for (int k = 0; k < 16; k++) b[k] = d[127 - 8*k -: 8];
        n = 16;
        if (last) begin
            p  = int'(b[15]);
            ok = (p >= 1) && (p <= 16);
            if (ok) begin
                for (int k = 16 - p; k < 16; k++) if (int'(b[k]) != p) ok = 1'b0;
            end
            n = ok ? 16 - p : 0;
            if (!ok) exp_pad = 1'b1;
            exp_dones++;
        end
        for (int k = 0; k < n; k++) exp_q.push_back(b[k]);
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] with_pad(input logic [127:0] d, input int p);
        for (int k = 16 - p; k < 16; k++) d[127 - 8*k -: 8] = 8'(p);
        return d;
    endfunction

    task automatic send_block(input logic [127:0] d, input bit last, input bit modelled);
        blk_valid = 1'b1;
        blk_data  = d;
        blk_last  = last;
        if (modelled) model_push(d, last);
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input int rdy_pct, input int stop_after);
        int  it;
        int  acc;
        bit  rdy;
        bit  fin;
        bit  held;
        logic [7:0] held_byte;
        it = 0; acc = 0; fin = 1'b0; held = 1'b0; held_byte = 8'h00;
        first_iter = -1; last_iter = -1; done_iter = -1; gaps = 0; done_seen = 0;
        while (it < budget) begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_byte", 32'(out_byte), 32'(held_byte));
            end
            if (out_valid === 1'b1 && first_iter < 0) first_iter = it;
            if (msg_done === 1'b1) begin
                done_seen++;
                done_iter = it;
            end
            if (first_iter >= 0 && exp_q.size() > 0 && out_valid !== 1'b1) gaps++;
            rdy = ($urandom_range(99) < rdy_pct);
            out_ready = rdy;
            held = (out_valid === 1'b1) && !rdy;
            held_byte = out_byte;
            if (out_valid === 1'b1 && rdy) begin
                if (exp_q.size() == 0) chk("extra_byte", 32'd1, 32'd0);
                else chk("byte", 32'(out_byte), 32'(exp_q.pop_front()));
                acc++;
                last_iter = it;
            end
            @(negedge clk);
            it++;
            if (stop_after > 0 && acc == stop_after) begin
                fin = 1'b1;
                break;
            end
            if (exp_q.size() == 0 && done_seen == exp_dones && out_valid !== 1'b1
                && msg_done !== 1'b1 && it > 2) begin
                fin = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
        if (!fin) chk("timeout", 32'd1, 32'd0);
    endtask

    task automatic post_checks(input string tag);
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_seen), 32'(exp_dones));
        chk({tag, "_pad_err"}, 32'(pad_err), 32'(exp_pad));
        chk({tag, "_ovf_err"}, 32'(ovf_err), 32'(exp_ovf));
        exp_dones = 0;
    endtask

    task automatic do_reset();
        rest = 1'b1;
        @(negedge clk);
        rest = 1'b0;
        exp_q.delete();
        exp_dones = 0;
        exp_pad = 1'b0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        rest = 1'b1; blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_byte", 32'(out_byte), 32'd0);
        chk("rst_blk_ready", 32'(blk_ready), 32'd1);
        chk("rst_msg_done", 32'(msg_done), 32'd0);
        chk("rst_pad_err", 32'(pad_err), 32'd0);
        chk("rst_ovf_err", 32'(ovf_err), 32'd0);
        rest = 1'b0;
        @(negedge clk);

        send_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 1'b1);
        drain(100, 100, 0);
        chk("t1_first_latency", 32'(first_iter), 32'd2);
        chk("t1_gaps", 32'(gaps), 32'd0);
        post_checks("t1");

        send_block(with_pad(rand_blk(), 3), 1'b1, 1'b1);
        drain(200, 60, 0);
        chk("t2_done_after_last", 32'(done_iter), 32'(last_iter + 1));
        post_checks("t2");

        d = with_pad(rand_blk(), 5);
        d[31:24] = 8'h04;
        send_block(d, 1'b1, 1'b1);
        drain(100, 100, 0);
        post_checks("t3");
        send_block(rand_blk(), 1'b0, 1'b1);
        drain(200, 70, 0);
        post_checks("t3_after");

        send_block({16{8'h10}}, 1'b1, 1'b1);
        drain(100, 100, 0);
        chk("t4_done_iter", 32'(done_iter), 32'd2);
        post_checks("t4");
        do_reset();
        send_block({{15{8'h10}}, 8'h00}, 1'b1, 1'b1);
        drain(100, 100, 0);
        post_checks("t4_p00");
        do_reset();
        send_block({{15{8'h10}}, 8'h11}, 1'b1, 1'b1);
        drain(100, 100, 0);
        post_checks("t4_p11");

        // Three back-to-back blocks with the sink stalled: third must be dropped.
        do_reset();
        blk_valid = 1'b1; blk_data = rand_blk(); blk_last = 1'b0; model_push(blk_data, 1'b0);
        @(negedge clk);
        blk_data = rand_blk(); model_push(blk_data, 1'b0);
        @(negedge clk);
        chk("t5_blk_ready_full", 32'(blk_ready), 32'd0);
        blk_data = rand_blk();
        @(negedge clk);
        blk_valid = 1'b0;
        exp_ovf = 1'b1;
        chk("t5_ovf_set", 32'(ovf_err), 32'd1);
        drain(200, 100, 0);
        chk("t5_bubble", 32'(gaps), 32'd1);
        post_checks("t5");

        for (int n = 0; n < 20; n++) begin
            bit last;
            last = $urandom_range(1);
            d = rand_blk();
            if (last && $urandom_range(3) != 0) d = with_pad(d, int'($urandom_range(16, 1)));
            send_block(d, last, 1'b1);
            drain(300, 60, 0);
            post_checks("rnd");
        end

        send_block(rand_blk(), 1'b0, 1'b1);
        drain(300, 50, 7);
        rest = 1'b1;
        @(negedge clk);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_blk_ready", 32'(blk_ready), 32'd1);
        chk("t6_pad_err", 32'(pad_err), 32'd0);
        chk("t6_ovf_err", 32'(ovf_err), 32'd0);
        chk("t6_msg_done", 32'(msg_done), 32'd0);
        rest = 1'b0;
        exp_q.delete(); exp_dones = 0; exp_pad = 1'b0; exp_ovf = 1'b0;
        send_block(rand_blk(), 1'b0, 1'b1);
        drain(300, 60, 0);
        post_checks("t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_plain_unpacker.md
Name: aes_plain_unpacker

Overview:
- Downstream stage of the AES-128 inverse-cipher FSM.
- Captures each 128-bit decrypted block when the decryptor raises its `done` pulse and buffers up to two blocks.
- On the final block of a message, checks and strips PKCS#7 padding.
- Streams the plaintext bytes over a valid/ready byte interface to the password-record parser.

Parameters:
- PAD_EN, 1, 1 = validate and strip PKCS#7 padding on the last block; 0 = emit all 16 bytes of every block.
- BLK_W, 128, block width in bits; fixed at 128, not to be overridden.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rest  in  1  synchronous active-high reset
- blk_valid  in  1  one-cycle pulse; blk_data is valid (driven from decryptor done)
- blk_data  in  128  decrypted block; bits 127:120 = byte 0
- blk_last  in  1  qualifies blk_valid; this block ends the message
- blk_ready  out  1  buffer has at least one free entry; the controller starts a decryption only while high
- out_byte  out  8  plaintext byte
- out_valid  out  1  out_byte is valid
- out_ready  in  1  sink accepts the byte
- msg_done  out  1  one-cycle pulse; message fully handled
- pad_err  out  1  sticky; the last block had invalid padding
- ovf_err  out  1  sticky; blk_valid arrived while the buffer was full

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rest is synchronous and active-high.
  - Reset mid-operation discards all buffered data.
  - Reset values: state=IDLE, buffer empty, blk_ready=1, out_valid=0, out_byte=0, msg_done=0, pad_err=0, ovf_err=0.
- Buffer:
  - 2-entry FIFO of {blk_data, blk_last}.
  - Written on blk_valid when not full.
  - blk_ready = !full.
  - blk_valid while full: block dropped, ovf_err set; FIFO contents unchanged.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- FSM states: IDLE, LOAD, STREAM, FINISH.
  - IDLE: FIFO non-empty -> LOAD.
  - LOAD (1 cycle):
    - Pop the head into a 128-bit shift register and set idx=0.
    - Compute cnt:
      - Non-last block, or PAD_EN=0: cnt=16.
      - Last block with PAD_EN=1: p = byte 15. Valid if 1<=p<=16 and bytes 16-p..15 all equal p; then cnt=16-p.
      - Invalid padding: cnt=0 and pad_err set.
    - Next state:
      - cnt>0 -> STREAM.
      - cnt=0 and last -> FINISH.
      - cnt=0 and not last cannot occur.
  - STREAM:
    - out_valid=1; out_byte = shift register bits 127:120.
    - On out_valid&out_ready: shift left 8 and idx++.
    - When the byte with idx=cnt-1 is accepted:
      - Last block -> FINISH.
      - Else FIFO non-empty -> LOAD.
      - Else -> IDLE.
    - out_byte and out_valid stay stable while out_ready=0.
  - FINISH (1 cycle): msg_done=1, then -> IDLE (or LOAD if the FIFO is non-empty).
- Latency:
  - blk_valid captured at edge t; LOAD at cycle t+1; first out_valid at cycle t+2.
  - One bubble cycle (LOAD) between consecutive blocks.
- Boundary cases:
  - p=16: last block emits 0 bytes; msg_done still pulses.
  - pad_err clears only on rest.
  - Data from blocks after a pad error is still streamed normally.
  - With PAD_EN=0, msg_done follows the 16th byte of a blk_last block.
- Widths: idx and cnt are 5 bits (0..16); the padding compare is unsigned 8-bit.

Decomposition:
- Package aes_stream_pkg holds:
  - BLK_BYTES=16, FIFO_DEPTH=2.
  - The state enum encoding (IDLE=0, LOAD=1, STREAM=2, FINISH=3).
  - The byte-lane extraction function.
- One combinational sub-module, pkcs7_check:
  - Input: a 128-bit block.
  - Outputs: pad_ok and cnt[4:0].
  - Instantiated in the LOAD datapath.

Test Plan:
- Single non-last block 00112233_44556677_8899AABB_CCDDEEFF, out_ready=1 -> bytes 00,11,...,FF on 16 consecutive cycles starting 2 cycles after blk_valid; no msg_done.
- Last block whose bytes 13..15 = 03,03,03 -> 13 bytes emitted, msg_done pulses exactly once one cycle after the 13th byte is accepted; pad_err=0.
- Last block ending in 05 with byte 12=04 -> 0 bytes emitted, pad_err=1 (sticky), msg_done pulses; a later valid block still streams.
- Last block of all 10h -> no bytes, msg_done one cycle after LOAD; same block with byte 15=00 or 11h -> pad_err=1.
- Three blk_valid pulses 1 cycle apart with out_ready=0 -> blk_ready drops after 2, third block dropped, ovf_err=1; releasing out_ready streams exactly 32 bytes with one bubble cycle between blocks.
- Random out_ready backpressure mid-block, then rest asserted at byte 7 -> out_valid=0, blk_ready=1, errors clear next cycle; a following block streams from byte 0.
